piso_nbit_tx: RTL and testbench
===============================

# piso_nbit_tx

Parallel-in, serial-out transmitter for N-bit words: the sending end of the team's serial shift-register link. It accepts one parallel word through a valid/ready handshake and drives it out one bit per clock with a frame strobe, so a serial-in shift register at the far end can collect it. Back-to-back words stream with no idle cycle between them.

## Interface
- N, 16, data word width; legal range N >= 2
- LSB_FIRST, 0, 0 = bit N-1 goes out first; 1 = bit 0 goes out first

- clk  input  1  rising-edge clock
- reset_al_in  input  1  asynchronous, active-low reset
- p_in  input  N  parallel word to transmit
- valid_in  input  1  p_in holds a word to send
- ready_out  output  1  transmitter accepts a word at this edge
- d_out  output  1  serial data bit
- frame_out  output  1  d_out carries a valid bit this cycle
- last_out  output  1  current bit is the final bit of the frame

## Operation
- States: IDLE, SHIFT. Bit counter width $clog2(F+1), where F is the frame length (N, or N+1 with parity).
- Accept: valid_in & ready_out at a rising edge. The shift register captures p_in and the counter clears. The state moves to (or stays in) SHIFT.
- ready_out = (state == IDLE) | last_out. It is combinational from registers and never depends on valid_in.
- SHIFT: d_out is the current head bit of the shift register. Each edge shifts by one and increments the counter. frame_out = 1.
- last_out = 1 when counter == F-1 in SHIFT.
- At the edge ending the last bit:
  - With an accept: the next word's first bit follows immediately.
  - Without an accept: return to IDLE.
- IDLE: d_out = 0, frame_out = 0, last_out = 0. valid_in low is ignored.
- p_in and valid_in are don't-care except at accepting edges. Changing p_in mid-frame has no effect.
- Reset asserted mid-frame aborts the word immediately. No remaining bits are sent and nothing is retried.

## Timing
- Reset values: state IDLE, counter 0, shift register 0.
  - d_out = 0, frame_out = 0, last_out = 0.
  - ready_out = 1.
- Latency: a word accepted at edge k presents its first bit from edge k until edge k+1. Bit i is valid between edges k+i and k+i+1.
- A frame occupies exactly F cycles. Continuous streaming gives throughput 1 bit/clock.
- Reset release is synchronous to the design via the team's reset synchronizer upstream. This block only treats reset_al_in as asynchronous assert.

## Configuration
- Macro PISO_TX_PARITY_EN.
- Defined: an even-parity bit over the N data bits is computed at accept and sent as bit F = N+1 after the data bits. last_out marks the parity bit.
- Undefined: F = N, no parity logic, and last_out marks data bit N-1 in send order.

## Structure
- Shared package/include: state encodings (IDLE, SHIFT), and the counter-width function/localparam based on $clog2.
- The parity header and PISO_TX_PARITY_EN guard live in the same shared include used by the matching receiver, so both ends agree on F.
- One sub-module: parity_even_nbit (N-bit XOR-reduce, parameter N). It is instantiated only under PISO_TX_PARITY_EN.

## Test plan
- Reset: hold reset_al_in = 0 for 3 cycles, then release. Required: ready_out = 1, frame_out = 0, d_out = 0. No activity with valid_in = 0 for 20 cycles.
- Single word: N = 16, LSB_FIRST = 0, p_in = 16'hA5C3 pulsed valid for one cycle. Required:
  - d_out = 1010 0101 1100 0011 over 16 cycles.
  - frame_out high for exactly 16 cycles, last_out high on cycle 16 only.
  - With parity: a 17th bit 0, and last_out on bit 17.
- Back-to-back: valid_in held high with 16'hFFFF, then 16'h0001. Required:
  - 32 contiguous framed bits with no gap.
  - ready_out high only in the last-bit cycles and in IDLE.
  - With parity: the parity bits are 0 (for 16'hFFFF) and 1 (for 16'h0001).
- LSB_FIRST = 1, p_in = 16'h8001. Required: first bit 1, then 14 zeros, then 1.
- Reset mid-frame: assert reset after bit 5 of 16'hA5C3. Required:
  - Outputs go to reset values asynchronously.
  - After release, the next accepted word 16'h1234 is sent complete and uncorrupted.
- Ignored input: change p_in every cycle during a frame with valid_in = 1. Required: only the word captured at the accepting edge is sent, and the next word is captured only at the last-bit edge.

Source files
------------

// File: rtl/piso_nbit_tx_pkg.sv
// Shared definitions for the piso_nbit_tx serial link (transmitter and matching receiver).
// Build option: define PISO_TX_PARITY_EN to append an even-parity bit to every frame.
// Both ends of the link read the frame length from here, so they always agree on F.
package piso_nbit_tx_pkg;

  // Transmitter sequencing states
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

`ifdef PISO_TX_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  // Frame length in bits: data word plus the optional parity bit
  function automatic int frame_len(input int n);
    return PARITY_EN ? (n + 1) : n;
  endfunction

  // Width of a counter that can hold 0..f
  function automatic int cnt_width(input int f);
    return $clog2(f + 1);
  endfunction

endpackage

// File: rtl/piso_nbit_tx_parity_even_nbit.sv
// Even-parity generator over an N-bit word (XOR reduction).
// Only elaborated when PISO_TX_PARITY_EN is defined; the default build has no parity logic.
`ifdef PISO_TX_PARITY_EN
module parity_even_nbit #(
  parameter int N = 16
) (
  input  logic [N-1:0] data,
  output logic         parity
);

  // Parity bit that makes the total count of ones (data + parity) even
  function automatic logic even_parity(input logic [N-1:0] w);
    return ^w;
  endfunction

  assign parity = even_parity(data);

endmodule
`endif

// File: rtl/piso_nbit_tx.sv
// Parallel-in, serial-out transmitter: takes an N-bit word over valid/ready and sends
// it one bit per clock with frame/last strobes; back-to-back words stream gap-free.
// Build option: PISO_TX_PARITY_EN appends an even-parity bit after the data bits.
module piso_nbit_tx
  import piso_nbit_tx_pkg::*;
#(
  parameter int N         = 16,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         reset_al_in,
  input  logic [N-1:0] p_in,
  input  logic         valid_in,
  output logic         ready_out,
  output logic         d_out,
  output logic         frame_out,
  output logic         last_out
);

  localparam int F  = frame_len(N);
  localparam int CW = cnt_width(F);
  // Counter value one before the final bit: reaching it next edge means "last bit"
  localparam logic [CW-1:0] PRELAST_IDX = CW'(F - 2);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [F-1:0]  sreg;
  logic          last_r;

  logic [F-1:0]  load_word;
  logic [F-1:0]  sreg_shifted;
  logic          head;
  logic          accept;

`ifdef PISO_TX_PARITY_EN
  logic par;

  parity_even_nbit #(.N(N)) u_parity (
    .data   (p_in),
    .parity (par)
  );

  // Parity always trails the data bits, whichever end is sent first
  assign load_word = LSB_FIRST ? {par, p_in} : {p_in, par};
`else
  assign load_word = p_in;
`endif

  // The head bit sits at the end that leaves first; zeros fill in behind it, so an
  // exhausted register reads as zero once the frame is over.
  assign head         = LSB_FIRST ? sreg[0] : sreg[F-1];
  assign sreg_shifted = LSB_FIRST ? {1'b0, sreg[F-1:1]} : {sreg[F-2:0], 1'b0};

  // Ready in IDLE or while the final bit is on the wire, so the next word follows at once
  assign ready_out = (state == IDLE) | last_r;
  assign accept    = valid_in & ready_out;

  assign d_out     = (state == SHIFT) & head;
  assign frame_out = (state == SHIFT);
  assign last_out  = last_r;

  // Sequencer: load on accept, shift one bit per clock, return to IDLE after the last bit
  always_ff @(posedge clk or negedge reset_al_in) begin
    if (!reset_al_in) begin
      state  <= IDLE;
      cnt    <= '0;
      sreg   <= '0;
      last_r <= 1'b0;
    end else if (accept) begin
      state  <= SHIFT;
      cnt    <= '0;
      sreg   <= load_word;
      last_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state  <= IDLE;
          cnt    <= '0;
          sreg   <= sreg;
          last_r <= 1'b0;
        end
        SHIFT: begin
          sreg <= sreg_shifted;
          if (last_r) begin
            state  <= IDLE;
            cnt    <= '0;
            last_r <= 1'b0;
          end else begin
            state  <= SHIFT;
            cnt    <= cnt + CW'(1);
            last_r <= (cnt == PRELAST_IDX);
          end
        end
        default: begin
          state  <= IDLE;
          cnt    <= '0;
          sreg   <= '0;
          last_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_nbit_tx.sv
// Scoreboard bench for piso_nbit_tx: one MSB-first and one LSB-first instance share
// stimulus; a reference model queues the expected serial bits of every accepted word.
module tb_piso_nbit_tx;

  localparam int N = 16;
`ifdef PISO_TX_PARITY_EN
  localparam int F   = N + 1;
  localparam bit PAR = 1'b1;
`else
  localparam int F   = N;
  localparam bit PAR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_al_in;
  logic [N-1:0] p_in;
  logic         valid_in;

  logic ready_m, d_m, frame_m, last_m;
  logic ready_l, d_l, frame_l, last_l;

  int n_cmp = 0;
  int n_err = 0;

  // Expected wire contents, one entry per clock: {bit, last}
  logic [1:0] q_m[$];
  logic [1:0] q_l[$];

  // Serial capture of each instance's framed bits, oldest bit in the highest position
  logic [63:0] cap_m, cap_l;
  int          cap_n;

  always #5 clk = ~clk;

  piso_nbit_tx #(.N(N), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .reset_al_in(reset_al_in), .p_in(p_in), .valid_in(valid_in),
    .ready_out(ready_m), .d_out(d_m), .frame_out(frame_m), .last_out(last_m)
  );

  piso_nbit_tx #(.N(N), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .reset_al_in(reset_al_in), .p_in(p_in), .valid_in(valid_in),
    .ready_out(ready_l), .d_out(d_l), .frame_out(frame_l), .last_out(last_l)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame contents as an integer, first-sent bit most significant
  function automatic logic [63:0] frame_bits(input logic [N-1:0] w);
    logic [63:0] v;
    v = {48'd0, w};
    if (PAR) v = (v << 1) | {63'd0, ^w};
    return v;
  endfunction

  // Queue the F bits of one word in send order for both bit orders
  function automatic void push_word(input logic [N-1:0] w);
    for (int i = 0; i < F; i++) begin
      logic bm, bl, lst;
      if (i < N) begin
        bm = w[N-1-i];
        bl = w[i];
      end else begin
        bm = ^w;
        bl = ^w;
      end
      lst = (i == F - 1);
      q_m.push_back({bm, lst});
      q_l.push_back({bl, lst});
    end
  endfunction

  // Reference model: a word is taken when the wire is idle or carrying its final bit
  always @(posedge clk or negedge reset_al_in) begin
    if (!reset_al_in) begin
      q_m.delete();
      q_l.delete();
    end else begin
      bit acc;
      acc = valid_in && (q_m.size() <= 1);
      if (q_m.size() > 0) void'(q_m.pop_front());
      if (q_l.size() > 0) void'(q_l.pop_front());
      if (acc) push_word(p_in);
    end
  end

  task automatic chk_out(input string tag, input logic d, input logic f, input logic l,
                         input logic r, input int sz, input logic [1:0] hd);
    chk({tag, " frame_out"}, {63'd0, f}, {63'd0, (sz > 0)});
    chk({tag, " d_out"},     {63'd0, d}, {63'd0, hd[1]});
    chk({tag, " last_out"},  {63'd0, l}, {63'd0, hd[0]});
    chk({tag, " ready_out"}, {63'd0, r}, {63'd0, (sz <= 1)});
  endtask

  // Monitor: compare both instances against the queue heads on the falling edge
  always @(negedge clk) begin
    chk_out("msb", d_m, frame_m, last_m, ready_m, q_m.size(), (q_m.size() > 0) ? q_m[0] : 2'b00);
    chk_out("lsb", d_l, frame_l, last_l, ready_l, q_l.size(), (q_l.size() > 0) ? q_l[0] : 2'b00);
    if (frame_m) begin
      cap_m = {cap_m[62:0], d_m};
      cap_n++;
    end
    if (frame_l) cap_l = {cap_l[62:0], d_l};
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_cap();
    cap_m = '0;
    cap_l = '0;
    cap_n = 0;
  endtask

  task automatic send_one(input logic [N-1:0] w);
    valid_in = 1'b1;
    p_in     = w;
    tick();
    valid_in = 1'b0;
    p_in     = 16'($urandom);
  endtask

  initial begin
    reset_al_in = 1'b0;
    valid_in    = 1'b0;
    p_in        = '0;
    clear_cap();
    repeat (3) tick();
    reset_al_in = 1'b1;

    // Idle: valid low must produce no activity
    repeat (20) begin
      p_in = 16'($urandom);
      tick();
    end
    chk("idle no frame", 64'(cap_n), 64'd0);

    // Single word, MSB first
    clear_cap();
    send_one(16'hA5C3);
    repeat (F + 3) tick();
    chk("single len", 64'(cap_n), 64'(F));
    chk("single bits", cap_m, frame_bits(16'hA5C3));

    // Back-to-back: FFFF then 0001 with valid held high
    clear_cap();
    valid_in = 1'b1;
    p_in     = 16'hFFFF;
    tick();
    p_in = 16'h0001;
    repeat (F) tick();
    valid_in = 1'b0;
    repeat (F + 3) tick();
    chk("b2b len", 64'(cap_n), 64'(2 * F));
    chk("b2b bits", cap_m, (frame_bits(16'hFFFF) << F) | frame_bits(16'h0001));

    // LSB-first ordering of 8001: 1, fourteen zeros, 1 (palindrome on the wire)
    clear_cap();
    send_one(16'h8001);
    repeat (F + 3) tick();
    chk("lsb bits", cap_l, frame_bits(16'h8001));

    // Reset mid-frame: abort after bit 5 is on the wire
    send_one(16'hA5C3);
    repeat (5) tick();
    #1;
    reset_al_in = 1'b0;
    #1;
    chk("async rst frame", {63'd0, frame_m}, 64'd0);
    chk("async rst d",     {63'd0, d_m},     64'd0);
    chk("async rst last",  {63'd0, last_m},  64'd0);
    chk("async rst ready", {63'd0, ready_m}, 64'd1);
    chk("async rst lsb frame", {63'd0, frame_l}, 64'd0);
    tick();
    tick();
    reset_al_in = 1'b1;
    tick();
    clear_cap();
    send_one(16'h1234);
    repeat (F + 3) tick();
    chk("post rst len", 64'(cap_n), 64'(F));
    chk("post rst bits", cap_m, frame_bits(16'h1234));

    // Ignored input: valid held high while p_in changes every cycle
    valid_in = 1'b1;
    repeat (4 * F) begin
      p_in = 16'($urandom);
      tick();
    end
    valid_in = 1'b0;
    repeat (F + 2) tick();

    // Random traffic with sporadic valid
    repeat (300) begin
      valid_in = ($urandom_range(0, 3) != 0);
      p_in     = 16'($urandom);
      tick();
    end
    valid_in = 1'b0;
    repeat (F + 3) tick();
    chk("drained", 64'(q_m.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
